// File: rtl/pipe_stage_skid_reg_if.sv
// Handshake bundle between pipeline stages.
// Carries payload, PC, branch-delay flag and exception code.
interface pipe_stage_skid_reg_if #(
   parameter int DATA_W = 64,
   parameter int PC_W   = 32,
   parameter int EXC_W  = 5
) ();
   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] payload;
   logic [PC_W-1:0]   pc;
   logic              bd;
   logic [EXC_W-1:0]  exc;

   modport master (
      output valid, payload, pc, bd, exc,
      input  ready
   );

   modport slave (
      input  valid, payload, pc, bd, exc,
      output ready
   );
endinterface

// File: rtl/pipe_stage_skid_reg.sv
// Inter-stage pipeline register with valid/ready handshake,
// optional one-entry skid buffer, trap flush and bubble insertion.
module pipe_stage_skid_reg #(
   parameter int              DATA_W     = 64,
   parameter int              PC_W       = 32,
   parameter int              EXC_W      = 5,
   parameter logic [PC_W-1:0] RESET_PC   = 'h0000_3000,
   parameter logic [PC_W-1:0] HANDLER_PC = 'h0000_4180,
   parameter bit              SKID       = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  req,
   input  logic                  clear,
   pipe_stage_skid_reg_if.slave  in_if,
   pipe_stage_skid_reg_if.master out_if,
   output logic [1:0]            occupancy
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_e;

   typedef struct packed {
      logic [DATA_W-1:0] payload;
      logic [PC_W-1:0]   pc;
      logic              bd;
      logic [EXC_W-1:0]  exc;
   } beat_t;

   localparam beat_t RST_BEAT = '{
      payload: '0, pc: RESET_PC, bd: 1'b0, exc: '0
   };

   state_e state_q, state_d;
   beat_t  main_q, main_d;
   beat_t  skid_q, skid_d;
   beat_t  in_beat;
   logic   room;
   logic   xfer_in;
   logic   xfer_out;

   assign in_beat = '{
      payload: in_if.payload,
      pc:      in_if.pc,
      bd:      in_if.bd,
      exc:     in_if.exc
   };

   // With the skid, ready depends only on our own state, never out_ready.
   assign room = SKID ? (state_q != FULL)
                      : ((state_q == EMPTY) | out_if.ready);

   assign in_if.ready    = room & ~req & ~clear;
   assign out_if.valid   = (state_q != EMPTY);
   assign out_if.payload = main_q.payload;
   assign out_if.pc      = main_q.pc;
   assign out_if.bd      = main_q.bd;
   assign out_if.exc     = main_q.exc;
   assign occupancy      = state_q;

   assign xfer_in  = in_if.valid & in_if.ready;
   assign xfer_out = out_if.valid & out_if.ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (req) begin
         state_d = EMPTY;
         main_d  = '{payload: '0, pc: HANDLER_PC,
                     bd: 1'b0, exc: '0};
      end else if (clear) begin
         // Bubble keeps PC/BD so CP0 can still form EPC.
         state_d = EMPTY;
         main_d  = '{payload: '0, pc: in_if.pc,
                     bd: in_if.bd, exc: '0};
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (xfer_in) begin
                  main_d  = in_beat;
                  state_d = ONE;
               end
            end
            ONE: begin
               if (xfer_in && xfer_out) begin
                  main_d = in_beat;
               end else if (xfer_in && SKID) begin
                  skid_d  = in_beat;
                  state_d = FULL;
               end else if (xfer_out) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (xfer_out) begin
                  main_d  = skid_q;
                  state_d = ONE;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= EMPTY;
         main_q  <= RST_BEAT;
         skid_q  <= RST_BEAT;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Scoreboard bench for pipe_stage_skid_reg.
// Covers both the skid and the single-entry build.
module tb_pipe_stage_skid_reg;

   localparam int DW = 64;
   localparam int PW = 32;
   localparam int EW = 5;

   typedef logic [127:0] w_t;

   logic       clk     = 1'b0;
   logic       reset_n = 1'b1;
   logic       req     = 1'b0;
   logic       clear   = 1'b0;
   logic [1:0] occ;
   logic [1:0] occ0;

   int n_cmp = 0;
   int n_err = 0;
   w_t q[$];
   w_t q0[$];

   always #5 clk = ~clk;

   pipe_stage_skid_reg_if #(.DATA_W(DW), .PC_W(PW), .EXC_W(EW)) u  ();
   pipe_stage_skid_reg_if #(.DATA_W(DW), .PC_W(PW), .EXC_W(EW)) d  ();
   pipe_stage_skid_reg_if #(.DATA_W(DW), .PC_W(PW), .EXC_W(EW)) u0 ();
   pipe_stage_skid_reg_if #(.DATA_W(DW), .PC_W(PW), .EXC_W(EW)) d0 ();

   pipe_stage_skid_reg #(
      .DATA_W(DW), .PC_W(PW), .EXC_W(EW), .SKID(1'b1)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req       (req),
      .clear     (clear),
      .in_if     (u),
      .out_if    (d),
      .occupancy (occ)
   );

   pipe_stage_skid_reg #(
      .DATA_W(DW), .PC_W(PW), .EXC_W(EW), .SKID(1'b0)
   ) dut0 (
      .clk       (clk),
      .reset_n   (reset_n),
      .req       (1'b0),
      .clear     (1'b0),
      .in_if     (u0),
      .out_if    (d0),
      .occupancy (occ0)
   );

   function automatic w_t pack(input logic [DW-1:0] pl,
                               input logic [PW-1:0] pc,
                               input logic          bd,
                               input logic [EW-1:0] ex);
      return w_t'({pl, pc, bd, ex});
   endfunction

   task automatic check(input string tag, input w_t obs,
                        input w_t exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [DW-1:0] pl,
                        input logic [PW-1:0] pc, input logic bd,
                        input logic [EW-1:0] ex);
      u.valid   = v;
      u.payload = pl;
      u.pc      = pc;
      u.bd      = bd;
      u.exc     = ex;
   endtask

   always @(negedge clk) begin
      if (!reset_n) begin
         q.delete();
      end else begin
         if (d.valid && d.ready) begin
            check("sb_nonempty", w_t'(q.size() != 0), 1);
            if (q.size() != 0)
               check("beat", pack(d.payload, d.pc, d.bd, d.exc),
                     q.pop_front());
         end
         if (req || clear)
            q.delete();
         else if (u.valid && u.ready)
            q.push_back(pack(u.payload, u.pc, u.bd, u.exc));
      end
   end

   always @(negedge clk) begin
      if (!reset_n) begin
         q0.delete();
      end else begin
         if (d0.valid && d0.ready) begin
            check("sb0_nonempty", w_t'(q0.size() != 0), 1);
            if (q0.size() != 0)
               check("beat0", pack(d0.payload, d0.pc, d0.bd, d0.exc),
                     q0.pop_front());
         end
         if (u0.valid && u0.ready)
            q0.push_back(pack(u0.payload, u0.pc, u0.bd, u0.exc));
      end
   end

   initial begin
      logic [PW-1:0] pc0;
      logic          rdy;
      logic          acc;

      drive(0, '0, '0, 0, '0);
      d.ready    = 1'b0;
      u0.valid   = 1'b0;
      u0.payload = '0;
      u0.pc      = '0;
      u0.bd      = 1'b0;
      u0.exc     = '0;
      d0.ready   = 1'b0;

      // reset state
      #1 reset_n = 1'b0;
      #1;
      check("rst_valid", d.valid, 0);
      check("rst_pc", d.pc, 'h3000);
      check("rst_payload", d.payload, 0);
      check("rst_in_ready", u.ready, 1);
      check("rst_occ", occ, 0);
      step();
      step();
      reset_n = 1'b1;
      #1 check("rel_in_ready", u.ready, 1);

      // back-to-back streaming
      d.ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1, DW'(i + 1), PW'(32'h3000 + 4 * i), 0, '0);
         if (i == 0) check("lat_pre", d.valid, 0);
         step();
         check("p1_valid", d.valid, 1);
         check("p1_pc", d.pc, 32'h3000 + 4 * i);
         check("p1_occ", occ, 1);
      end
      drive(0, '0, '0, 0, '0);
      step();
      check("p1_drain", d.valid, 0);
      check("p1_hold_pc", d.pc, 'h300C);
      check("p1_occ0", occ, 0);

      // stall into FULL, then drain
      d.ready = 1'b0;
      drive(1, 'hA, 'h3010, 0, '0);
      step();
      check("p2_occA", occ, 1);
      check("p2_rdyA", u.ready, 1);
      drive(1, 'hB, 'h3014, 1, 5'd2);
      step();
      check("p2_occB", occ, 2);
      check("p2_rdyB", u.ready, 0);
      check("p2_pcB", d.pc, 'h3010);
      drive(0, '0, '0, 0, '0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("p2_hold_occ", occ, 2);
         check("p2_hold_pc", d.pc, 'h3010);
      end
      d.ready = 1'b1;
      step();
      check("p2_out1_occ", occ, 1);
      check("p2_out1_pc", d.pc, 'h3014);
      step();
      check("p2_out2_occ", occ, 0);
      check("p2_out2_valid", d.valid, 0);

      // trap flush while FULL
      d.ready = 1'b0;
      drive(1, 'hC, 'h3018, 1, 5'd3);
      step();
      drive(1, 'hD, 'h301C, 0, '0);
      step();
      check("p3_full", occ, 2);
      drive(1, 'hE, 'h3020, 0, '0);
      req = 1'b1;
      #1 check("p3_req_rdy", u.ready, 0);
      drive(0, '0, '0, 0, '0);
      step();
      req = 1'b0;
      check("p3_valid", d.valid, 0);
      check("p3_pc", d.pc, 'h4180);
      check("p3_bd", d.bd, 0);
      check("p3_exc", d.exc, 0);
      check("p3_payload", d.payload, 0);
      check("p3_occ", occ, 0);
      d.ready = 1'b1;
      drive(1, 'h55, 'h4180, 0, '0);
      step();
      check("p3_next_valid", d.valid, 1);
      check("p3_next_pc", d.pc, 'h4180);
      drive(0, '0, '0, 0, '0);
      step();

      // bubble insertion
      clear = 1'b1;
      drive(1, 'hAA, 'h3020, 1, 5'd7);
      #1 check("p4_clr_rdy", u.ready, 0);
      step();
      clear = 1'b0;
      check("p4_valid", d.valid, 0);
      check("p4_pc", d.pc, 'h3020);
      check("p4_bd", d.bd, 1);
      check("p4_exc", d.exc, 0);
      check("p4_payload", d.payload, 0);
      check("p4_occ", occ, 0);
      #1 check("p4_rdy", u.ready, 1);
      step();
      check("p4_re_valid", d.valid, 1);
      check("p4_re_pc", d.pc, 'h3020);
      check("p4_re_exc", d.exc, 7);
      check("p4_re_payload", d.payload, 'hAA);
      drive(0, '0, '0, 0, '0);
      step();

      // req beats clear
      req   = 1'b1;
      clear = 1'b1;
      drive(0, '0, 'h3030, 1, '0);
      step();
      req   = 1'b0;
      clear = 1'b0;
      check("p5_pc", d.pc, 'h4180);
      check("p5_bd", d.bd, 0);
      check("p5_occ", occ, 0);

      // async reset while FULL
      d.ready = 1'b0;
      drive(1, 'h40, 'h3040, 0, '0);
      step();
      drive(1, 'h44, 'h3044, 0, '0);
      step();
      check("p5_full", occ, 2);
      drive(0, '0, '0, 0, '0);
      #2 reset_n = 1'b0;
      #1;
      check("p5_rst_valid", d.valid, 0);
      check("p5_rst_pc", d.pc, 'h3000);
      check("p5_rst_rdy", u.ready, 1);
      check("p5_rst_occ", occ, 0);
      check("p5_rst_payload", d.payload, 0);
      step();
      reset_n = 1'b1;
      d.ready = 1'b1;
      step();

      // single-entry build, out_ready toggling
      pc0      = 'h5000;
      u0.valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         rdy        = (i % 2 == 0);
         d0.ready   = rdy;
         u0.pc      = pc0;
         u0.payload = DW'(pc0);
         #1;
         acc = (q0.size() == 0) || rdy;
         check("s0_in_ready", u0.ready, w_t'(acc));
         check("s0_occ", occ0, w_t'(q0.size()));
         check("s0_occ_max", w_t'(occ0 <= 2'd1), 1);
         step();
         if (acc) pc0 = pc0 + 4;
      end
      u0.valid = 1'b0;
      d0.ready = 1'b1;
      repeat (3) step();

      check("sb_drain", w_t'(q.size()), 0);
      check("sb0_drain", w_t'(q0.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
